// File: rtl/bcd_display_driver.sv
// bcd_display_driver: serial double-dabble binary-to-BCD converter (one bit per
// clock) feeding one seven-segment decoder per digit, with leading-zero
// blanking and an overflow flag for values that do not fit in DIGITS digits.
// Segment encoding everywhere is active-low {g,f,e,d,c,b,a}.

// Single-digit decoder: 0-9 map to glyphs, 10-15 (never produced) show dark.
module sevenseg (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    // Active-low glyph lookup
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = 7'b1111111;
        endcase
    end
endmodule

module bcd_display_driver #(
    parameter int         WIDTH         = 8,
    parameter int         DIGITS        = 3,
    parameter bit         BLANK_LZ      = 1'b1,
    parameter logic [6:0] BLANK_PATTERN = 7'b1111111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      num,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   lcd
);
    // Internal digits sized so the full input range never truncates; the
    // displayed digits are the low DIGITS of these.
    localparam int MIN_DIG    = (WIDTH + 2) / 3 + 1;
    localparam int INT_DIGITS = (DIGITS > MIN_DIG) ? DIGITS : MIN_DIG;
    localparam int CW         = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, CONV} state_e;

    state_e                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic [WIDTH-1:0]              sh_q;
    logic [INT_DIGITS-1:0][3:0]    dig_q;
    logic [DIGITS-1:0][3:0]        bcd_q;
    logic                          busy_q, done_q, ovf_q;

    logic [INT_DIGITS-1:0][3:0]    adj;
    logic [INT_DIGITS-1:0][3:0]    dig_d;
    logic [WIDTH-1:0]              sh_d;
    logic                          ovf_d;

    // One double-dabble step: per-digit +3 (no inter-digit carry), then shift
    always_comb begin
        adj = dig_q;
        for (int d = 0; d < INT_DIGITS; d++) begin
            if (dig_q[d] >= 4'd5) adj[d] = dig_q[d] + 4'd3;
        end
        {dig_d, sh_d} = {adj, sh_q} << 1;
        ovf_d = 1'b0;
        for (int d = DIGITS; d < INT_DIGITS; d++) begin
            ovf_d = ovf_d | (|dig_d[d]);
        end
    end

    // Conversion FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            dig_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CONV;
                        busy_q  <= 1'b1;
                        sh_q    <= num;
                        dig_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                    end
                end
                CONV: begin
                    sh_q  <= sh_d;
                    dig_q <= dig_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Last shift: publish results on the same edge
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= dig_d[DIGITS-1:0];
                        ovf_q   <= ovf_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd      = bcd_q;

    logic [DIGITS-1:0] blank;
    logic              seen;

    // Blank digit i>0 when it and every digit above it are zero
    always_comb begin
        seen  = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen     = seen | (|bcd_q[i]);
            blank[i] = BLANK_LZ && (i != 0) && !seen;
        end
    end

    logic [DIGITS-1:0][6:0] seg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        sevenseg u_seg (
            .bcd_i (bcd_q[g]),
            .seg_o (seg[g])
        );
        assign lcd[7*g +: 7] = blank[g] ? BLANK_PATTERN : seg[g];
    end

endmodule

// File: tb/tb_bcd_display_driver.sv
// Bench for bcd_display_driver: several parameterisations side by side,
// checked against a decimal-arithmetic reference model.
module tb_bcd_display_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start8, start16;
    logic [7:0]  num8;
    logic [15:0] num16;

    logic busy_a, done_a, ovf_a;  logic [11:0] bcd_a; logic [20:0] lcd_a;
    logic busy_b, done_b, ovf_b;  logic [7:0]  bcd_b; logic [13:0] lcd_b;
    logic busy_c, done_c, ovf_c;  logic [11:0] bcd_c; logic [20:0] lcd_c;
    logic busy_d, done_d, ovf_d;  logic [19:0] bcd_d; logic [34:0] lcd_d;
    logic busy_e, done_e, ovf_e;  logic [15:0] bcd_e; logic [27:0] lcd_e;

    bcd_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut_a (
        .clk(clk), .rst(rst), .start(start8), .num(num8), .busy(busy_a),
        .done(done_a), .overflow(ovf_a), .bcd(bcd_a), .lcd(lcd_a));
    bcd_display_driver #(.WIDTH(8), .DIGITS(2), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start8), .num(num8), .busy(busy_b),
        .done(done_b), .overflow(ovf_b), .bcd(bcd_b), .lcd(lcd_b));
    bcd_display_driver #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut_c (
        .clk(clk), .rst(rst), .start(start8), .num(num8), .busy(busy_c),
        .done(done_c), .overflow(ovf_c), .bcd(bcd_c), .lcd(lcd_c));
    bcd_display_driver #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut_d (
        .clk(clk), .rst(rst), .start(start16), .num(num16), .busy(busy_d),
        .done(done_d), .overflow(ovf_d), .bcd(bcd_d), .lcd(lcd_d));
    bcd_display_driver #(.WIDTH(16), .DIGITS(4), .BLANK_LZ(1'b1)) dut_e (
        .clk(clk), .rst(rst), .start(start16), .num(num16), .busy(busy_e),
        .done(done_e), .overflow(ovf_e), .bcd(bcd_e), .lcd(lcd_e));

    int vecs = 0;
    int errs = 0;
    bit overlap = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---- reference model: plain decimal arithmetic ----
    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic longint p10(input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [63:0] m_bcd(input longint n, input int D);
        logic [63:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((n / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] m_ovf(input longint n, input int D);
        return (n >= p10(D)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] m_lcd(input longint n, input int D, input bit blz);
        logic [63:0] r = '0;
        longint shown = n % p10(D);
        for (int i = 0; i < D; i++) begin
            if (blz && i > 0 && shown < p10(i)) r[7*i +: 7] = 7'b1111111;
            else                               r[7*i +: 7] = glyph(int'((n / p10(i)) % 10));
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if ((busy_a && done_a) || (busy_d && done_d)) overlap = 1'b1;
    end

    task automatic check8(input int n);
        chk("bcd_d3",  64'(bcd_a), m_bcd(n, 3));
        chk("ovf_d3",  64'(ovf_a), m_ovf(n, 3));
        chk("lcd_d3",  64'(lcd_a), m_lcd(n, 3, 1'b1));
        chk("bcd_d2",  64'(bcd_b), m_bcd(n, 2));
        chk("ovf_d2",  64'(ovf_b), m_ovf(n, 2));
        chk("lcd_d2",  64'(lcd_b), m_lcd(n, 2, 1'b1));
        chk("lcd_nolz", 64'(lcd_c), m_lcd(n, 3, 1'b0));
    endtask

    task automatic check16(input int n);
        chk("bcd_w16d5", 64'(bcd_d), m_bcd(n, 5));
        chk("ovf_w16d5", 64'(ovf_d), m_ovf(n, 5));
        chk("lcd_w16d5", 64'(lcd_d), m_lcd(n, 5, 1'b1));
        chk("bcd_w16d4", 64'(bcd_e), m_bcd(n, 4));
        chk("ovf_w16d4", 64'(ovf_e), m_ovf(n, 4));
        chk("lcd_w16d4", 64'(lcd_e), m_lcd(n, 4, 1'b1));
    endtask

    // Count edges after the accepting edge until done; optionally pokes start mid-run
    task automatic wait8(input bit poke, output int cyc, output int nb);
        cyc = 0;
        nb  = busy_a ? 1 : 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            start8 = (poke && cyc == 3);
            if (busy_a) nb++;
        end while (!done_a && cyc < 40);
        start8 = 1'b0;
    endtask

    task automatic run8(input int n, input bit poke);
        int cyc, nb;
        @(negedge clk); num8 = 8'(n); start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0; num8 = 8'($urandom);
        wait8(poke, cyc, nb);
        chk("lat8", 64'(cyc), 64'd8);
        chk("busy8", 64'(nb), 64'd8);
        check8(n);
        @(posedge clk); #1;
        chk("pulse8", 64'(done_a), 64'd0);
    endtask

    task automatic run16(input int n);
        int cyc;
        @(negedge clk); num16 = 16'(n); start16 = 1'b1;
        @(posedge clk); #1; start16 = 1'b0; num16 = 16'($urandom);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!done_d && cyc < 60);
        chk("lat16", 64'(cyc), 64'd16);
        chk("done_w16d4", 64'(done_e), 64'd1);
        check16(n);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy_a), 64'd0);
        chk({tag, "_done"}, 64'(done_a), 64'd0);
        chk({tag, "_ovf"},  64'(ovf_a),  64'd0);
        chk({tag, "_bcd"},  64'(bcd_a),  64'd0);
        chk({tag, "_lcd"},  64'(lcd_a),  m_lcd(0, 3, 1'b1));
        chk({tag, "_lcdnolz"}, 64'(lcd_c), m_lcd(0, 3, 1'b0));
    endtask

    initial begin
        int cyc, nb, gap;
        bit saw_done;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; num8 = '0; num16 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");
        chk("rst0_w16_lcd", 64'(lcd_d), m_lcd(0, 5, 1'b1));
        @(negedge clk); rst = 1'b0;

        // directed values, including a stray start mid-conversion
        run8(255, 1'b0);
        run8(0,   1'b0);
        run8(7,   1'b0);
        run8(105, 1'b1);
        run8(123, 1'b0);
        run8(99,  1'b0);

        // back-to-back: start held in the done cycle
        @(negedge clk); num8 = 8'd42; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        wait8(1'b0, cyc, nb);
        check8(42);
        num8 = 8'd200; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0; num8 = 8'd0;
        wait8(1'b0, cyc, nb);
        gap = cyc + 1;
        chk("b2b_gap", 64'(gap), 64'd9);
        check8(200);

        // reset mid-conversion aborts with no done
        @(negedge clk); num8 = 8'd250; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rstmid");
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (done_a) saw_done = 1'b1; end
        chk("rstmid_nodone", 64'(saw_done), 64'd0);
        run8(19, 1'b0);

        // random 8-bit
        for (int k = 0; k < 25; k++) run8(int'($urandom_range(0, 255)), k[0]);

        // 16-bit
        run16(65535);
        run16(0);
        run16(9999);
        run16(10000);
        for (int k = 0; k < 10; k++) run16(int'($urandom_range(0, 65535)));

        chk("busy_done_overlap", 64'(overlap), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
